// File: rtl/fifo_prog.sv
// rtl/fifo_prog.sv - synchronous FIFO with programmable thresholds, error pulses and optional FWFT read
module fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = FIFO_DEPTH - 4,
    parameter int AE_THRESH  = 4,
    localparam int BITS      = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen_a,
    input  logic [FIFO_WIDTH-1:0] din_a,
    input  logic                  ren_b,
    output logic [FIFO_WIDTH-1:0] dout_b,
    output logic                  valid_b,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [BITS:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [BITS:0] DEPTH_LVL = (BITS+1)'(FIFO_DEPTH);
    localparam logic [BITS:0] AF_LVL    = (BITS+1)'(AF_THRESH);
    localparam logic [BITS:0] AE_LVL    = (BITS+1)'(AE_THRESH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [BITS:0]         wr_ptr;
    logic [BITS:0]         rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  mem_empty;
    logic                  mem_we;
    logic                  mem_re;
    logic                  bypass;
    logic                  valid_q;

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_LVL);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign rd_acc    = ren_b && !empty;
    assign wr_acc    = wen_a && (!full || rd_acc);
    assign mem_empty = (wr_ptr == rd_ptr);

    // In FWFT mode the output register holds the head word, so the memory
    // only sees words behind it; the register refills from memory first,
    // and takes din_a directly when the memory has nothing older.
    always_comb begin
        mem_we = wr_acc;
        mem_re = rd_acc;
        bypass = 1'b0;
        if (FWFT != 0) begin
            mem_re = 1'b0;
            if (rd_acc || empty) begin
                if (!mem_empty) begin
                    mem_re = 1'b1;
                end else if (wr_acc) begin
                    bypass = 1'b1;
                    mem_we = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[wr_ptr[BITS-1:0]] <= din_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout_b    <= '0;
            valid_q   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (mem_re) begin
                dout_b <= mem[rd_ptr[BITS-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end else if (bypass) begin
                dout_b <= din_a;
            end
            if (mem_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            valid_q   <= rd_acc;
            overflow  <= wen_a && !wr_acc;
            underflow <= ren_b && !rd_acc;
        end
    end

    assign valid_b = (FWFT != 0) ? !empty : valid_q;

endmodule

// File: tb/tb_fifo_prog.sv
// tb/tb_fifo_prog.sv - checks standard and FWFT fifo_prog instances against a queue model
module tb_fifo_prog;
    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wen = 1'b0;
    logic         ren = 1'b0;
    logic [W-1:0] din = '0;

    logic [W-1:0] dout0, dout1;
    logic         valid0, full0, empty0, af0, ae0, ovf0, udf0;
    logic         valid1, full1, empty1, af1, ae1, ovf1, udf1;
    logic [3:0]   cnt0, cnt1;

    always #5 clk = ~clk;

    fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0), .AF_THRESH(4), .AE_THRESH(2)) u_std (
        .clk(clk), .rst(rst), .wen_a(wen), .din_a(din), .ren_b(ren),
        .dout_b(dout0), .valid_b(valid0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(udf0)
    );

    fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1), .AF_THRESH(4), .AE_THRESH(2)) u_fwft (
        .clk(clk), .rst(rst), .wen_a(wen), .din_a(din), .ren_b(ren),
        .dout_b(dout1), .valid_b(valid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(udf1)
    );

    int checks   = 0;
    int failures = 0;
    bit run      = 1'b0;

    // Model: one queue of every stored word; both modes accept identically.
    logic [W-1:0] q[$];
    logic [W-1:0] ed0 = '0;
    logic [W-1:0] ed1 = '0;
    logic         ev0 = 1'b0;
    logic         eo  = 1'b0;
    logic         eu  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit rd, wr;
        if (rst) begin
            q.delete();
            ed0 = '0;
            ed1 = '0;
            ev0 = 1'b0;
            eo  = 1'b0;
            eu  = 1'b0;
        end else begin
            rd  = ren && (q.size() > 0);
            wr  = wen && ((q.size() < D) || rd);
            ev0 = rd;
            if (rd) ed0 = q.pop_front();
            if (wr) q.push_back(din);
            if (q.size() > 0) ed1 = q[0];
            eo  = wen && !wr;
            eu  = ren && !rd;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("m_count0", cnt0, q.size());
            chk("m_full0",  full0,  q.size() == D);
            chk("m_empty0", empty0, q.size() == 0);
            chk("m_af0",    af0,    q.size() >= 4);
            chk("m_ae0",    ae0,    q.size() <= 2);
            chk("m_dout0",  dout0,  ed0);
            chk("m_valid0", valid0, ev0);
            chk("m_ovf0",   ovf0,   eo);
            chk("m_udf0",   udf0,   eu);
            chk("m_count1", cnt1, q.size());
            chk("m_full1",  full1,  q.size() == D);
            chk("m_empty1", empty1, q.size() == 0);
            chk("m_af1",    af1,    q.size() >= 4);
            chk("m_ae1",    ae1,    q.size() <= 2);
            chk("m_valid1", valid1, q.size() != 0);
            if (q.size() != 0) chk("m_dout1", dout1, ed1);
            chk("m_ovf1",   ovf1,   eo);
            chk("m_udf1",   udf1,   eu);
        end
    end

    task automatic step(input logic w, input logic [W-1:0] d, input logic r);
        wen = w;
        din = d;
        ren = r;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        run = 1'b1;
        step(1'b1, 16'h0077, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("rst_count",  cnt0, 0);
        chk("rst_empty",  empty0, 1);
        chk("rst_ae",     ae0, 1);
        chk("rst_full",   full0, 0);
        chk("rst_dout0",  dout0, 0);
        chk("rst_dout1",  dout1, 0);
        chk("rst_valid0", valid0, 0);
        chk("rst_valid1", valid1, 0);
        chk("rst_ovf",    ovf0, 0);
        chk("rst_udf",    udf0, 0);
        rst = 1'b0;

        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 16'(i), 1'b0);
            if (i == 3) chk("af_before", af0, 0);
            if (i == 4) chk("af_at4", af0, 1);
            if (i == 7) chk("full_before", full0, 0);
            if (i == 8) chk("full_at8", full0, 1);
        end
        step(1'b1, 16'h0009, 1'b0);
        chk("ovf_pulse0", ovf0, 1);
        chk("ovf_pulse1", ovf1, 1);
        chk("ovf_count",  cnt0, 8);
        step(1'b0, '0, 1'b0);
        chk("ovf_clear", ovf0, 0);
        chk("fwft_head", dout1, 1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, '0, 1'b1);
            chk("rd_data",  dout0, i);
            chk("rd_valid", valid0, 1);
            if (i < 8) chk("fwft_next", dout1, i + 1);
        end
        step(1'b0, '0, 1'b0);
        chk("drain_valid0", valid0, 0);
        chk("drain_empty",  empty0, 1);
        chk("drain_valid1", valid1, 0);

        for (int i = 0; i < 8; i++) step(1'b1, 16'(32 + i), 1'b0);
        step(1'b1, 16'h0099, 1'b1);
        chk("fullrw_count", cnt0, 8);
        chk("fullrw_full",  full0, 1);
        chk("fullrw_dout",  dout0, 16'h0020);
        chk("fullrw_valid", valid0, 1);
        chk("fullrw_head1", dout1, 16'h0021);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, '0, 1'b1);
            chk("fullrw_drain", dout0, 32 + i);
        end
        step(1'b0, '0, 1'b1);
        chk("fullrw_last", dout0, 16'h0099);
        step(1'b1, 16'h0055, 1'b1);
        chk("emptyrw_count", cnt0, 1);
        chk("emptyrw_udf",   udf0, 1);
        chk("emptyrw_valid", valid0, 0);
        chk("emptyrw_hold",  dout0, 16'h0099);
        chk("emptyrw_v1",    valid1, 1);
        chk("emptyrw_d1",    dout1, 16'h0055);
        step(1'b0, '0, 1'b1);
        chk("emptyrw_rd", dout0, 16'h0055);

        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) step(1'b1, 16'(p * 16 + i), 1'b0);
            chk("wrap_full",  full0, 1);
            chk("wrap_full1", full1, 1);
            for (int i = 0; i < 8; i++) begin
                step(1'b0, '0, 1'b1);
                chk("wrap_data", dout0, p * 16 + i);
            end
            chk("wrap_empty", empty0, 1);
        end

        step(1'b1, 16'h00A5, 1'b0);
        chk("ft_valid", valid1, 1);
        chk("ft_data",  dout1, 16'h00A5);
        step(1'b0, '0, 1'b0);
        chk("ft_hold", dout1, 16'h00A5);
        step(1'b0, '0, 1'b1);
        chk("ft_pop_empty", empty1, 1);
        chk("ft_std_rd",    dout0, 16'h00A5);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 16'(16 + k), 1'b1);
            chk("stream_valid", valid1, 1);
            chk("stream_data",  dout1, 16 + k);
            if (k == 0) chk("stream_udf", udf1, 1);
            else        chk("stream_cnt", cnt1, 1);
        end
        step(1'b0, '0, 1'b1);
        chk("stream_end",  empty1, 1);
        chk("stream_std",  dout0, 16'h0017);

        for (int i = 0; i < 5; i++) step(1'b1, 16'(64 + i), 1'b0);
        chk("mid_count", cnt0, 5);
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        rst = 1'b0;
        chk("mid_rst_count",  cnt0, 0);
        chk("mid_rst_empty",  empty0, 1);
        chk("mid_rst_valid0", valid0, 0);
        chk("mid_rst_valid1", valid1, 0);
        step(1'b1, 16'h003C, 1'b0);
        chk("post_rst_d1", dout1, 16'h003C);
        chk("post_rst_v1", valid1, 1);
        step(1'b0, '0, 1'b1);
        chk("post_rst_d0", dout0, 16'h003C);
        chk("post_rst_v0", valid0, 1);
        step(1'b0, '0, 1'b0);
        chk("post_rst_empty", empty0, 1);

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
